// File: rtl/adc_seq_pkg.sv
// adc_seq_pkg: shared definitions for the SAR conversion sequencer.
//   state_t   : sequencer FSM states
//   ACC_W     : accumulator width for the default build (DW + OSR_MAX)
//   clamp_osr : limits a requested oversampling exponent to the legal maximum
package adc_seq_pkg;

  localparam int DW_DEF      = 8;
  localparam int OSR_MAX_DEF = 4;
  localparam int ACC_W       = DW_DEF + OSR_MAX_DEF;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT,
    ACC,
    PUB
  } state_t;

  function automatic logic [2:0] clamp_osr(input logic [2:0] osr,
                                           input logic [2:0] osr_max);
    return (osr > osr_max) ? osr_max : osr;
  endfunction

endpackage

// File: rtl/adc_seq_timer.sv
// adc_seq_timer: reloadable down-counter that paces conversion starts.
//   clk, rst : clock and synchronous active-high reset
//   en       : counter runs only while high; a rising edge reloads the count
//   period   : cycles between ticks (0 behaves as 1)
//   tick     : one-cycle strobe when the count reaches zero
module adc_seq_timer
  import adc_seq_pkg::*;
#(
  parameter int PER_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [PER_W-1:0] period,
  output logic             tick
);

  logic [PER_W-1:0] cnt_p0;
  logic [PER_W-1:0] reload;
  logic             en_q;
  logic             en_rise;

  assign en_rise = en & ~en_q;
  assign reload  = (period == '0) ? '0 : period - 1'b1;
  // The rise cycle only reloads; a stale zero from reset must not fire a tick.
  assign tick    = en & ~en_rise & (cnt_p0 == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_p0 <= '0;
      en_q   <= 1'b0;
    end else begin
      en_q <= en;
      if (en_rise || tick) begin
        cnt_p0 <= reload;
      end else if (en) begin
        cnt_p0 <= cnt_p0 - 1'b1;
      end
    end
  end

endmodule

// File: rtl/adc_seq.sv
// adc_seq: conversion sequencer in front of the SAR ADC macro.
// Starts a conversion every `period` cycles, captures each SAR result,
// averages 2^osr_log2 samples and offers the average on a valid/ready port.
//   clk, rst            : clock, synchronous active-high reset
//   en                  : sequencer enable (level)
//   period, osr_log2    : pacing and oversampling exponent (clamped to OSR_MAX)
//   adc_start/done/data : SAR macro handshake
//   res_data/valid/ready: averaged result toward the host
//   ovr, to_err, clr_err: sticky overrun / timeout flags and their clear
// Build option: define ADC_SEQ_ROUND_EN for round-half-up averaging with
// saturation; otherwise the average is truncated.
module adc_seq
  import adc_seq_pkg::*;
#(
  parameter int DW      = 8,
  parameter int PER_W   = 16,
  parameter int OSR_MAX = 4,
  parameter int TO_CYC  = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [PER_W-1:0] period,
  input  logic [2:0]       osr_log2,
  output logic             adc_start,
  input  logic             adc_done,
  input  logic [DW-1:0]    adc_data,
  output logic [DW-1:0]    res_data,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             ovr,
  output logic             to_err,
  input  logic             clr_err
);

  localparam int              AW      = DW + OSR_MAX;
  localparam int              TO_W    = $clog2(TO_CYC);
  localparam logic [2:0]      OSR_CAP = 3'(OSR_MAX);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYC - 1);

  state_t             state_q, state_d;
  logic               tick;
  logic               done_q;
  logic               done_rise;
  logic               timeout;
  logic [TO_W-1:0]    to_cnt;
  logic [2:0]         osr_q;
  logic [OSR_MAX:0]   cnt;
  logic [OSR_MAX:0]   burst_last;
  logic [DW-1:0]      samp_p0;
  logic [AW-1:0]      acc_p1;

  function automatic logic [DW-1:0] publish(input logic [AW-1:0] acc,
                                            input logic [2:0]    osr);
`ifdef ADC_SEQ_ROUND_EN
    logic [AW:0] sum;
    logic [AW:0] shifted;
    sum     = {1'b0, acc} + ((osr == 3'd0) ? '0 : ((AW+1)'(1) << (osr - 3'd1)));
    shifted = sum >> osr;
    return (shifted > (AW+1)'({DW{1'b1}})) ? {DW{1'b1}} : shifted[DW-1:0];
`else
    logic [AW-1:0] shifted;
    shifted = acc >> osr;
    return shifted[DW-1:0];
`endif
  endfunction

  adc_seq_timer #(
    .PER_W(PER_W)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .period(period),
    .tick  (tick)
  );

  assign done_rise  = adc_done & ~done_q;
  assign timeout    = (state_q == WAIT) && !done_rise && (to_cnt == TO_LAST);
  assign burst_last = (OSR_MAX+1)'((32'd1 << osr_q) - 32'd1);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Ticks outside IDLE are simply not looked at, which drops them.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (tick && en) state_d = START;
      START:   state_d = WAIT;
      WAIT:    if (done_rise) state_d = ACC;
               else if (timeout) state_d = IDLE;
      ACC:     state_d = (cnt == burst_last) ? PUB : IDLE;
      PUB:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    adc_start = (state_q == START);
  end

  // Stage p0: SAR sample capture on the done edge
  always_ff @(posedge clk) begin
    if (state_q == WAIT && done_rise) samp_p0 <= adc_data;
  end

  // Stage p1: accumulation, burst bookkeeping, result and flags
  always_ff @(posedge clk) begin
    if (rst) begin
      done_q    <= 1'b0;
      to_cnt    <= '0;
      osr_q     <= '0;
      cnt       <= '0;
      acc_p1    <= '0;
      res_data  <= '0;
      res_valid <= 1'b0;
      ovr       <= 1'b0;
      to_err    <= 1'b0;
    end else begin
      done_q <= adc_done;

      if (state_q == START)     to_cnt <= '0;
      else if (state_q == WAIT) to_cnt <= to_cnt + 1'b1;

      // The exponent is frozen for the whole burst once the first sample lands.
      if (cnt == '0 && (state_q == IDLE || state_q == START || state_q == WAIT))
        osr_q <= clamp_osr(osr_log2, OSR_CAP);

      if (timeout) begin
        acc_p1 <= '0;
        cnt    <= '0;
      end else if (state_q == ACC) begin
        acc_p1 <= acc_p1 + AW'(samp_p0);
        cnt    <= cnt + 1'b1;
      end else if (state_q == PUB) begin
        acc_p1 <= '0;
        cnt    <= '0;
      end

      if (res_valid && res_ready) res_valid <= 1'b0;

      if (clr_err) begin
        ovr    <= 1'b0;
        to_err <= 1'b0;
      end

      // A result still waiting for the host is kept; the newer one is lost.
      if (state_q == PUB) begin
        if (!res_valid || res_ready) begin
          res_data  <= publish(acc_p1, osr_q);
          res_valid <= 1'b1;
        end else begin
          ovr <= 1'b1;
        end
      end

      if (timeout) to_err <= 1'b1;
    end
  end

endmodule
